// File: rtl/right_shift_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_seq_if
// Description : Request/result bundle between the ALU control and the
//               multi-cycle right shifter.
//                 start  ctrl -> shifter  request pulse
//                 A      ctrl -> shifter  operand to shift (WIDTH bits)
//                 B      ctrl -> shifter  shift amount (low bits used)
//                 sra    ctrl -> shifter  1 = arithmetic, 0 = logical
//                 C      shifter -> ctrl  last completed result
//                 busy   shifter -> ctrl  operation in flight
//                 done   shifter -> ctrl  one-cycle completion pulse
//               master = ALU control side, slave = shifter side.
// Revision    : 1.0  initial release
// ============================================================================
interface right_shift_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [31:0]      B;
  logic             sra;
  logic [WIDTH-1:0] C;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, sra,
    input  C, busy, done
  );

  modport slave (
    input  start, A, B, sra,
    output C, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/right_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_seq
// Description : Multi-cycle logical/arithmetic right shifter (SRL/SRA/SRLV/
//               SRAV). A request is latched on start while idle, the operand
//               is shifted a small step per cycle, and the result is returned
//               on C together with a one-cycle done pulse.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous, active-high reset
//               bus  - right_shift_seq_if.slave (start/A/B/sra in,
//                      C/busy/done out)
// Parameters  : WIDTH   - operand/result width (must match the interface)
//               SHAMT_W - number of low bits of B used as shift amount
// Build option: RSHIFT_FAST_EN - when defined, each shift cycle moves up to
//               4 bit positions (latency ceil(N/4)+1 instead of N+1).
// Revision    : 1.0  initial release
// ============================================================================
module right_shift_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  wire logic        clk,
  input  wire logic        rst,
  right_shift_seq_if.slave bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     w_acc_nxt;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [SHAMT_W-1:0]   w_cnt_nxt;
  logic                 r_arith;
  logic                 w_arith_nxt;
  logic [WIDTH-1:0]     r_c;
  logic [WIDTH-1:0]     w_c_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 r_done;
  logic                 w_done_nxt;

  // Shift datapath
  logic [SHAMT_W-1:0]   w_shamt;
  logic [SHAMT_W-1:0]   w_step;
  logic [SHAMT_W-1:0]   w_cnt_dec;
  logic                 w_fill;
  logic [WIDTH-1:0]     w_shifted;

  assign w_shamt = bus.B[SHAMT_W-1:0];

  // Only the low SHAMT_W bits of B select the shift amount.
  logic w_unused_b;
  assign w_unused_b = ^bus.B[31:SHAMT_W];

  // Fill bit comes from the latched operand's MSB so that A may change
  // freely once the request has been accepted.
  assign w_fill = r_arith & r_acc[WIDTH-1];

`ifdef RSHIFT_FAST_EN
  // Up to four positions per cycle; the final cycle takes whatever is left.
  assign w_step = (r_cnt > SHAMT_W'(4)) ? SHAMT_W'(4) : r_cnt;

  always_comb begin
    w_shifted = r_acc;
    case (w_step)
      SHAMT_W'(1): w_shifted = {w_fill,       r_acc[WIDTH-1:1]};
      SHAMT_W'(2): w_shifted = {{2{w_fill}},  r_acc[WIDTH-1:2]};
      SHAMT_W'(3): w_shifted = {{3{w_fill}},  r_acc[WIDTH-1:3]};
      SHAMT_W'(4): w_shifted = {{4{w_fill}},  r_acc[WIDTH-1:4]};
      default:     w_shifted = r_acc;
    endcase
  end
`else
  // Single-position stage: one bit per cycle.
  assign w_step    = SHAMT_W'(1);
  assign w_shifted = {w_fill, r_acc[WIDTH-1:1]};
`endif

  assign w_cnt_dec = r_cnt - w_step;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_arith <= 1'b0;
      r_c     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_arith <= w_arith_nxt;
      r_c     <= w_c_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  //
  // C and done are loaded on the edge that enters DONE, so during the DONE
  // cycle the result is already visible alongside the done pulse. busy and
  // done are both registered; start never reaches an output combinationally.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_arith_nxt = r_arith;
    w_c_nxt     = r_c;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_acc_nxt   = bus.A;
          w_cnt_nxt   = w_shamt;
          w_arith_nxt = bus.sra;
          w_busy_nxt  = 1'b1;
          if (w_shamt != '0) begin
            w_state_nxt = ST_SHIFT;
          end else begin
            // Zero shift: the operand itself is the result.
            w_state_nxt = ST_DONE;
            w_c_nxt     = bus.A;
            w_done_nxt  = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        w_acc_nxt = w_shifted;
        w_cnt_nxt = w_cnt_dec;
        if (w_cnt_dec == '0) begin
          w_state_nxt = ST_DONE;
          w_c_nxt     = w_shifted;
          w_done_nxt  = 1'b1;
        end
      end

      ST_DONE: begin
        // Any start seen here is dropped; the block is still busy.
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.C    = r_c;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_right_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_right_shift_seq
// Description : Self-checking bench for right_shift_seq. A cycle-level
//               reference (result from plain >> / >>>, latency from the
//               closed-form formula of the active build) is compared with
//               C/busy/done on every falling edge; directed operations also
//               pin results and latencies to hand-computed constants.
//               Honours RSHIFT_FAST_EN the same way as the design.
// Revision    : 1.0  initial release
// ============================================================================
module tb_right_shift_seq;

  localparam int WIDTH = 32;

`ifdef RSHIFT_FAST_EN
  localparam int L_B4  = 2;
  localparam int L_B8  = 3;
  localparam int L_B31 = 9;
  localparam int RST_WAIT = 0;
`else
  localparam int L_B4  = 5;
  localparam int L_B8  = 9;
  localparam int L_B31 = 32;
  localparam int RST_WAIT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  right_shift_seq_if #(.WIDTH(WIDTH)) bus ();

  right_shift_seq #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_print  = 0;
  int last_wait;

  // --------------------------------------------------------------------------
  // Reference arithmetic
  // --------------------------------------------------------------------------
  function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic s);
    int n;
    n = int'(b[4:0]);
    if (s) return $unsigned($signed(a) >>> n);
    else   return a >> n;
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    int n;
    n = int'(b[4:0]);
`ifdef RSHIFT_FAST_EN
    return (n + 3) / 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Cycle-level reference: an accepted request produces its result after
  // exp_lat() edges; the done cycle is followed by one cycle of idle.
  // --------------------------------------------------------------------------
  logic [31:0] m_c, m_res;
  logic        m_busy, m_done;
  int          m_left;

  initial begin
    m_c = '0; m_res = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_c    <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_c    <= m_res;
      end
      m_left <= m_left - 1;
    end else if (bus.start) begin
      m_busy <= 1'b1;
      m_res  <= ref_shift(bus.A, bus.B, bus.sra);
      m_left <= exp_lat(bus.B) - 1;
      if (exp_lat(bus.B) == 1) begin
        m_done <= 1'b1;
        m_c    <= ref_shift(bus.A, bus.B, bus.sra);
      end
    end
  end

  // Every-cycle comparison of the DUT against the reference.
  always @(negedge clk) begin
    n_checks++;
    if ({bus.C, bus.busy, bus.done} !== {m_c, m_busy, m_done}) begin
      n_fail++;
      if (n_print < 20) begin
        n_print++;
        $display("FAIL cycle_compare t=%0t: C=0x%08h busy=%b done=%b, expected C=0x%08h busy=%b done=%b",
                 $time, bus.C, bus.busy, bus.done, m_c, m_busy, m_done);
      end
    end else begin
      n_pass++;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  // Issue one request at the next idle falling edge and follow it to done.
  // junk: 0 = start low while busy, 1 = hold a fixed bogus request high
  // through SHIFT and DONE, 2 = random traffic while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] exp_c,
                        input int exp_l, input int junk, input string name);
    int  k;
    bit  seen;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    last_wait = k;
    if (bus.busy) begin
      check({name, " idle_timeout"}, 32'd1, 32'd0);
      return;
    end
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.sra   = s;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      case (junk)
        1: begin
          bus.start = 1'b1; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1; bus.sra = 1'b0;
        end
        2: begin
          bus.start = 1'($urandom_range(0, 1));
          bus.A = $urandom; bus.B = $urandom; bus.sra = 1'($urandom_range(0, 1));
        end
        default: bus.start = 1'b0;
      endcase
      if (bus.done) seen = 1'b1;
    end
    check({name, " latency"}, 32'(k), 32'(exp_l));
    check({name, " C"}, bus.C, exp_c);
    check({name, " model_C"}, m_c, exp_c);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [31:0] ra, rb;
    logic        rs;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.sra   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset C",    bus.C,    32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    rst = 1'b0;

    // Arithmetic vs logical fill at the extreme shift.
    run_op(32'h8000_0000, 32'd31, 1'b1, 32'hFFFF_FFFF, L_B31, 0, "sra31");
    run_op(32'h8000_0000, 32'd31, 1'b0, 32'h0000_0001, L_B31, 0, "srl31");

    // Zero shift with upper B bits set (masked away).
    run_op(32'hDEAD_BEEF, 32'h0000_0020, 1'b0, 32'hDEAD_BEEF, 1, 0, "zero_shift");
    idle(2);

    // Requests during SHIFT and DONE are dropped.
    run_op(32'h0000_00F0, 32'd4, 1'b0, 32'h0000_000F, L_B4, 1, "busy_protect");
    idle(3);
    check("busy_protect C held", bus.C, 32'h0000_000F);

    // Reset in the middle of a shift.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 32'hFFFF_0000; bus.B = 32'd8; bus.sra = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (RST_WAIT) @(negedge clk);
    check("pre_rst busy", 32'(bus.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst C",    bus.C,    32'h0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h1234_5678, 32'd4, 1'b0, 32'h0123_4567, L_B4, 0, "after_rst");

    // Back-to-back issue in the first idle cycle after done.
    run_op(32'hF000_0000, 32'd4, 1'b1, 32'hFF00_0000, L_B4, 0, "b2b_first");
    run_op(32'h0000_FF00, 32'd8, 1'b0, 32'h0000_00FF, L_B8, 0, "b2b_second");
    check("b2b no extra wait", 32'(last_wait), 32'd0);

    // Random operations with random traffic on the request lines while busy.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      idle($urandom_range(0, 2));
      run_op(ra, rb, rs, ref_shift(ra, rb, rs), exp_lat(rb), 2, "random");
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
